// File: rtl/uart16550_nasti_regs.sv
// uart16550_nasti_regs: AXI4-lite 16550 register subset with TX/RX byte FIFOs; optional loopback via UART16550_NASTI_LOOPBACK_EN
module uart16550_nasti_regs #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] aw_addr,
  input  logic       aw_valid,
  output logic       aw_ready,
  input  logic [7:0] w_data,
  input  logic       w_valid,
  output logic       w_ready,
  output logic [1:0] b_resp,
  output logic       b_valid,
  input  logic       b_ready,
  input  logic [2:0] ar_addr,
  input  logic       ar_valid,
  output logic       ar_ready,
  output logic [7:0] r_data,
  output logic [1:0] r_resp,
  output logic       r_valid,
  input  logic       r_ready,
  output logic [7:0] out_char,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic [7:0] in_char,
  input  logic       in_valid,
  output logic       in_ready
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  logic [7:0] dll, dlm, lcr, scr, rdata, rx_din;
  logic [3:0] ier;
  logic [4:0] mcr;
  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [7:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [AW:0] tx_cnt, rx_cnt;
  logic dlab, wr, rd, thr_wr, fcr_wr, loop, tx_full, rx_full;
  logic tx_push, tx_pop, rx_push, rx_pop, lb_push, thr_err, tx_flush, rx_flush;
`ifdef UART16550_NASTI_LOOPBACK_EN
  assign loop = mcr[4];
`else
  assign loop = 1'b0;
`endif
  assign dlab = lcr[7];
  assign aw_ready = !b_valid;
  assign w_ready = !b_valid;
  assign ar_ready = !r_valid;
  assign r_resp = 2'b00;
  assign wr = aw_valid & w_valid & !b_valid;
  assign rd = ar_valid & !r_valid;
  assign thr_wr = wr & (aw_addr == 3'd0) & !dlab;
  assign fcr_wr = wr & (aw_addr == 3'd2);
  assign tx_flush = fcr_wr & w_data[2];
  assign rx_flush = fcr_wr & w_data[1];
  assign tx_full = tx_cnt == FULL;
  assign rx_full = rx_cnt == FULL;
  assign out_valid = (tx_cnt != '0) & !loop;
  assign out_char = tx_mem[tx_rp];
  assign in_ready = !rx_full & !loop;
  assign tx_pop = out_valid & out_ready;
  assign tx_push = thr_wr & !loop & (!tx_full | tx_pop);
  assign lb_push = thr_wr & loop & !rx_full;
  assign thr_err = thr_wr & !tx_push & !lb_push;
  assign rx_push = (in_valid & in_ready) | lb_push;
  assign rx_din = lb_push ? w_data : in_char;
  assign rx_pop = rd & (ar_addr == 3'd0) & !dlab & (rx_cnt != '0);
  // read mux: register selected by address and DLAB
  always_comb begin
    case (ar_addr)
      3'd0: rdata = dlab ? dll : (rx_cnt != '0 ? rx_mem[rx_rp] : 8'h00);
      3'd1: rdata = dlab ? dlm : {4'h0, ier};
      3'd2: rdata = 8'h01;
      3'd3: rdata = lcr;
      3'd4: rdata = {3'b000, mcr};
      3'd5: rdata = {1'b0, tx_cnt == '0, tx_cnt == '0, 4'h0, rx_cnt != '0};
      3'd6: rdata = 8'h00;
      default: rdata = scr;
    endcase
  end
  // FIFO storage needs no reset; pointers and counts qualify it
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= w_data;
    if (rx_push) rx_mem[rx_wp] <= rx_din;
  end
  // FIFO pointers and occupancy counts; flush overrides traffic
  always_ff @(posedge clk) begin
    if (!rst || tx_flush) begin
      tx_wp <= '0;
      tx_rp <= '0;
      tx_cnt <= '0;
    end else begin
      tx_wp <= tx_wp + AW'(tx_push);
      tx_rp <= tx_rp + AW'(tx_pop);
      tx_cnt <= tx_cnt + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
    end
    if (!rst || rx_flush) begin
      rx_wp <= '0;
      rx_rp <= '0;
      rx_cnt <= '0;
    end else begin
      rx_wp <= rx_wp + AW'(rx_push);
      rx_rp <= rx_rp + AW'(rx_pop);
      rx_cnt <= rx_cnt + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
    end
  end
  // configuration registers written by accepted bus writes
  always_ff @(posedge clk) begin
    if (!rst) begin
      dll <= 8'h00;
      dlm <= 8'h00;
      ier <= 4'h0;
      lcr <= 8'h03;
      mcr <= 5'h00;
      scr <= 8'h00;
    end else if (wr) begin
      if (aw_addr == 3'd0 && dlab) dll <= w_data;
      if (aw_addr == 3'd1 && dlab) dlm <= w_data;
      if (aw_addr == 3'd1 && !dlab) ier <= w_data[3:0];
      if (aw_addr == 3'd3) lcr <= w_data;
      if (aw_addr == 3'd4) mcr <= w_data[4:0];
      if (aw_addr == 3'd7) scr <= w_data;
    end
  end
  // write response and read data channels
  always_ff @(posedge clk) begin
    if (!rst) begin
      b_valid <= 1'b0;
      b_resp <= 2'b00;
      r_valid <= 1'b0;
      r_data <= 8'h00;
    end else begin
      if (wr) begin
        b_valid <= 1'b1;
        b_resp <= thr_err ? 2'b10 : 2'b00;
      end else if (b_ready) b_valid <= 1'b0;
      if (rd) begin
        r_valid <= 1'b1;
        r_data <= rdata;
      end else if (r_ready) r_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart16550_nasti_regs.sv
// tb_uart16550_nasti_regs: scoreboard bench with directed vectors for uart16550_nasti_regs
module tb_uart16550_nasti_regs;
  logic clk = 0, rst = 0;
  logic [2:0] aw_addr = 0, ar_addr = 0;
  logic aw_valid = 0, w_valid = 0, b_ready = 1, ar_valid = 0, r_ready = 1;
  logic [7:0] w_data = 0, in_char = 0;
  logic out_ready = 0, in_valid = 0;
  logic aw_ready, w_ready, b_valid, ar_ready, r_valid, out_valid, in_ready;
  logic [1:0] b_resp, r_resp;
  logic [7:0] r_data, out_char;
  int total = 0, bad = 0;
  logic [1:0] exp_b [$];
  logic [7:0] exp_r [$];
  logic [7:0] exp_o [$];
  logic [7:0] hello [13] = '{8'h48, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h20, 8'h57, 8'h6f, 8'h72, 8'h6c, 8'h64, 8'h21, 8'h0a};

  uart16550_nasti_regs #(.FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready),
    .out_char(out_char), .out_valid(out_valid), .out_ready(out_ready),
    .in_char(in_char), .in_valid(in_valid), .in_ready(in_ready)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string n, input logic [7:0] a, input logic [7:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, a, e);
    end
  endfunction

  // monitor: every handshake on b, r and out is matched against the scoreboard
  always @(negedge clk) begin
    if (b_valid && b_ready) begin
      if (exp_b.size() == 0) chk("b_unexpected", 8'(b_resp), 8'hff);
      else chk("b_resp", 8'(b_resp), 8'(exp_b.pop_front()));
    end
    if (r_valid && r_ready) begin
      chk("r_resp", 8'(r_resp), 8'h00);
      if (exp_r.size() == 0) chk("r_unexpected", r_data, 8'hff);
      else chk("r_data", r_data, exp_r.pop_front());
    end
    if (out_valid && out_ready) begin
      if (exp_o.size() == 0) chk("out_unexpected", out_char, 8'hff);
      else chk("out_char", out_char, exp_o.pop_front());
    end
  end

  task automatic wr(input logic [2:0] a, input logic [7:0] d, input logic [1:0] e);
    int n = 0;
    exp_b.push_back(e);
    aw_addr = a;
    w_data = d;
    aw_valid = 1;
    w_valid = 1;
    @(negedge clk);
    while (!aw_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!aw_ready) chk("wr_timeout", 8'h0, 8'h1);
    @(posedge clk) #1;
    aw_valid = 0;
    w_valid = 0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] e);
    int n = 0;
    exp_r.push_back(e);
    ar_addr = a;
    ar_valid = 1;
    @(negedge clk);
    while (!ar_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ar_ready) chk("rd_timeout", 8'h0, 8'h1);
    @(posedge clk) #1;
    ar_valid = 0;
  endtask

  task automatic idle(input int c);
    repeat (c) @(posedge clk) #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    chk("rst_b_valid", 8'(b_valid), 8'h0);
    chk("rst_r_valid", 8'(r_valid), 8'h0);
    chk("rst_out_valid", 8'(out_valid), 8'h0);
    chk("rst_aw_ready", 8'(aw_ready), 8'h1);
    chk("rst_w_ready", 8'(w_ready), 8'h1);
    chk("rst_ar_ready", 8'(ar_ready), 8'h1);
    chk("rst_in_ready", 8'(in_ready), 8'h1);
    chk("rst_r_data", r_data, 8'h00);
    chk("rst_b_resp", 8'(b_resp), 8'h00);
    @(posedge clk) #1;
    rd(3, 8'h03);
    rd(5, 8'h60);
    rd(2, 8'h01);
    rd(6, 8'h00);
    wr(3, 8'h80, 2'b00);
    wr(0, 8'hde, 2'b00);
    wr(0, 8'had, 2'b00);
    wr(3, 8'h00, 2'b00);
    wr(3, 8'h80, 2'b00);
    rd(0, 8'had);
    rd(1, 8'h00);
    wr(3, 8'h00, 2'b00);
    idle(2);
    chk("div_out_valid", 8'(out_valid), 8'h0);
    wr(1, 8'hff, 2'b00);
    rd(1, 8'h0f);
    wr(4, 8'hef, 2'b00);
    rd(4, 8'h0f);
    wr(4, 8'h00, 2'b00);
    wr(7, 8'h3c, 2'b00);
    rd(7, 8'h3c);
    wr(5, 8'h12, 2'b00);
    wr(6, 8'h34, 2'b00);
    rd(5, 8'h60);
    out_ready = 1;
    exp_o.push_back(8'h48);
    wr(0, 8'h48, 2'b00);
    idle(3);
    rd(5, 8'h60);
    out_ready = 0;
    for (int i = 0; i < 13; i++) wr(0, hello[i], i < 8 ? 2'b00 : 2'b10);
    idle(2);
    chk("ovf_out_valid", 8'(out_valid), 8'h1);
    rd(5, 8'h00);
    for (int i = 0; i < 8; i++) exp_o.push_back(hello[i]);
    out_ready = 1;
    idle(12);
    chk("drain_out_valid", 8'(out_valid), 8'h0);
    in_valid = 1;
    in_char = 8'h41;
    @(posedge clk) #1;
    in_char = 8'h42;
    @(posedge clk) #1;
    in_valid = 0;
    rd(5, 8'h61);
    rd(0, 8'h41);
    rd(0, 8'h42);
    rd(0, 8'h00);
    rd(5, 8'h60);
    in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      in_char = 8'(8'h30 + i);
      @(posedge clk) #1;
    end
    in_valid = 0;
    @(negedge clk);
    chk("rx_full_in_ready", 8'(in_ready), 8'h0);
    @(posedge clk) #1;
    rd(0, 8'h30);
    rd(5, 8'h61);
    wr(2, 8'h02, 2'b00);
    rd(5, 8'h60);
    rd(0, 8'h00);
    @(negedge clk);
    chk("rx_flush_in_ready", 8'(in_ready), 8'h1);
    @(posedge clk) #1;
    out_ready = 0;
    wr(0, 8'h11, 2'b00);
    wr(0, 8'h22, 2'b00);
    rd(5, 8'h00);
    wr(2, 8'h04, 2'b00);
    rd(5, 8'h60);
    out_ready = 1;
    idle(3);
    b_ready = 0;
    wr(7, 8'h5a, 2'b00);
    idle(2);
    @(negedge clk);
    chk("bp_b_valid", 8'(b_valid), 8'h1);
    chk("bp_aw_ready", 8'(aw_ready), 8'h0);
    chk("bp_w_ready", 8'(w_ready), 8'h0);
    @(posedge clk) #1;
    aw_addr = 3;
    w_data = 8'h1b;
    aw_valid = 1;
    w_valid = 1;
    idle(3);
    aw_valid = 0;
    w_valid = 0;
    rst = 0;
    @(posedge clk) #1;
    rst = 1;
    exp_b.delete();
    @(negedge clk);
    chk("post_rst_b_valid", 8'(b_valid), 8'h0);
    @(posedge clk) #1;
    b_ready = 1;
    rd(3, 8'h03);
    rd(7, 8'h00);
    idle(6);
    chk("left_b", 8'(exp_b.size()), 8'h0);
    chk("left_r", 8'(exp_r.size()), 8'h0);
    chk("left_o", 8'(exp_o.size()), 8'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
